// File: rtl/core_boot_status_responder.sv
// Boot status responder, bridge clock domain.
//
// Watches the ready-to-run valid from the upstream stage and answers host
// status requests with a boot status word. When the host accepts a "ready"
// status, it pulses rtr_done once and sets the sticky running flag.
//
// Ports:
//   bridge_clk  - clock; all logic runs on its rising edge
//   reset       - synchronous, active-high reset
//   rtr_valid   - ready-to-run valid from the upstream stage
//   rtr_done    - one-cycle pulse when the handshake is complete
//   cmd_valid   - host command present
//   cmd_opcode  - host command opcode
//   cmd_ready   - block can accept a command this cycle
//   rsp_valid   - response word present
//   rsp_status  - response status word
//   rsp_ready   - host accepts the response
//   running     - sticky; core released to run
module core_boot_status_responder #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter logic [15:0] OPC_STATUS    = 16'h0000,
  parameter logic [15:0] ST_NOT_READY  = 16'h0001,
  parameter logic [15:0] ST_READY      = 16'h0003,
  parameter logic [15:0] ST_BAD_OPC    = 16'hFFFF
) (
  input  logic        bridge_clk,
  input  logic        reset,
  input  logic        rtr_valid,
  output logic        rtr_done,
  input  logic        cmd_valid,
  input  logic [15:0] cmd_opcode,
  output logic        cmd_ready,
  output logic        rsp_valid,
  output logic [15:0] rsp_status,
  input  logic        rsp_ready,
  output logic        running
);

  typedef enum logic [1:0] {StWait, StStable, StResp, StRun} state_e;

  localparam logic [15:0] StableCnt = 16'(STABLE_CYCLES);

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic [15:0] status_q, status_d;
  logic        ready_rsp_q, ready_rsp_d;
  logic        done_q, done_d;
  logic        running_q, running_d;

  logic stable;
  logic accept;
  logic xfer;

  assign stable = (count_q == StableCnt);
  assign accept = cmd_valid & cmd_ready;
  assign xfer   = rsp_valid & rsp_ready;

  // Stability counter; frozen once the core is running.
  always_comb begin
    count_d = count_q;
    if (!running_q) begin
      if (!rtr_valid) begin
        count_d = '0;
      end else if (!stable) begin
        count_d = count_q + 16'd1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    ready_rsp_d = ready_rsp_q;
    done_d      = 1'b0;
    running_d   = running_q;

    if (accept) begin
      if (cmd_opcode != OPC_STATUS) begin
        status_d = ST_BAD_OPC;
      end else if (state_q == StWait) begin
        status_d = ST_NOT_READY;
      end else begin
        status_d = ST_READY;
      end
      // Only a "ready" answer given before running completes the handshake.
      ready_rsp_d = (cmd_opcode == OPC_STATUS) && (state_q == StStable);
    end

    unique case (state_q)
      StWait: begin
        if (accept) begin
          state_d = StResp;
        end else if (stable) begin
          state_d = StStable;
        end
      end
      StStable: begin
        if (accept) begin
          state_d = StResp;
        end else if (!rtr_valid) begin
          state_d = StWait;
        end
      end
      StResp: begin
        if (xfer) begin
          if (running_q) begin
            state_d = StRun;
          end else if (ready_rsp_q) begin
            // Decision is final even if rtr_valid dropped while pending.
            state_d   = StRun;
            done_d    = 1'b1;
            running_d = 1'b1;
          end else begin
            state_d = stable ? StStable : StWait;
          end
        end
      end
      StRun: begin
        if (accept) begin
          state_d = StResp;
        end
      end
      default: state_d = StWait;
    endcase
  end

  always_ff @(posedge bridge_clk) begin
    if (reset) begin
      state_q     <= StWait;
      count_q     <= '0;
      status_q    <= '0;
      ready_rsp_q <= 1'b0;
      done_q      <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      status_q    <= status_d;
      ready_rsp_q <= ready_rsp_d;
      done_q      <= done_d;
      running_q   <= running_d;
    end
  end

  assign cmd_ready  = (state_q != StResp);
  assign rsp_valid  = (state_q == StResp);
  assign rsp_status = status_q;
  assign rtr_done   = done_q;
  assign running    = running_q;

endmodule

// File: doc/core_boot_status_responder.md
Name: core_boot_status_responder

Overview:
- Sits directly downstream of the core ready-to-run stage in the bridge clock domain.
- Consumes the ready-to-run valid and answers the host's status-request command with a boot status word.
- Closes the handshake by pulsing done once the host has accepted a "ready" status.
- Latches a sticky running flag that gates the rest of the core's start-up logic.

Parameters:
- STABLE_CYCLES, 16: consecutive cycles rtr_valid must be high before status reads "ready"; legal range 1..65535.
- OPC_STATUS, 16'h0000: opcode of the host status-request command.
- ST_NOT_READY, 16'h0001: status word returned while not yet stable.
- ST_READY, 16'h0003: status word returned once stable or running.
- ST_BAD_OPC, 16'hFFFF: status word returned for any unrecognised opcode.

Ports:
- bridge_clk  in  1  bridge clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- rtr_valid  in  1  ready-to-run valid from the upstream stage.
- rtr_done  out  1  one-cycle pulse telling the upstream stage that the handshake is complete.
- cmd_valid  in  1  host command present.
- cmd_opcode  in  16  host command opcode.
- cmd_ready  out  1  block can accept a command this cycle.
- rsp_valid  out  1  response word present.
- rsp_status  out  16  response status word.
- rsp_ready  in  1  host accepts the response.
- running  out  1  sticky; core released to run.

Behaviour:
- One clock (bridge_clk); reset is synchronous and active-high.
- Reset values: rtr_done=0, cmd_ready=1, rsp_valid=0, rsp_status=0, running=0, stability counter=0, state=WAIT.
- Stability counter:
  - 16 bits, increments while rtr_valid=1 and state is not RUN.
  - Saturates at STABLE_CYCLES.
  - Clears to 0 on any cycle rtr_valid=0.
  - stable = (count == STABLE_CYCLES).
  - rtr_valid high at cycle 0 gives stable=1 on the edge ending cycle STABLE_CYCLES-1.
- States:
  - WAIT: not stable. Enter STABLE when stable=1. A status request is answered with ST_NOT_READY.
  - STABLE: stable. Return to WAIT if rtr_valid drops. A status request is answered with ST_READY.
  - RESP: response pending. Entered on command accept. On accept of an ST_READY response: pulse rtr_done and go to RUN. On accept of any other response: go back to the state given by the current stable value.
  - RUN: terminal until reset. running=1. rtr_valid and the counter are ignored. Status requests are answered with ST_READY; rtr_done is not pulsed again.
- Command handshake:
  - cmd_ready=1 in WAIT, STABLE and RUN, 0 in RESP.
  - Accept = cmd_valid & cmd_ready.
  - Response status is decided from opcode and state at the accept edge:
    - opcode != OPC_STATUS → ST_BAD_OPC, in every state.
    - otherwise ST_NOT_READY in WAIT, ST_READY in STABLE or RUN.
  - rsp_valid rises the cycle after accept (1-cycle latency).
  - rsp_valid and rsp_status hold stable until rsp_ready=1; the transfer completes on rsp_valid & rsp_ready.
  - cmd_ready returns to 1 the cycle after the transfer completes. No back-to-back acceptance in the same cycle as a transfer.
- rtr_done:
  - High exactly one cycle, the cycle after the ST_READY response transfer.
  - running rises in the same cycle and stays 1.
- rtr_valid dropping while an ST_READY response is pending:
  - The response still completes as ST_READY.
  - rtr_done still pulses and running is still set; the host was told "ready" and that decision is final.
- Simultaneous reset and any event: reset wins. Pending responses are dropped with rsp_valid=0 next cycle, and running clears.

Test Plan:
- rtr_valid=1 continuously from cycle 0, STABLE_CYCLES=16, status request at cycle 5 → rsp_status=16'h0001, no rtr_done; second request at cycle 30 → rsp_status=16'h0003, rtr_done single pulse one cycle after rsp accept, running=1 thereafter.
- rtr_valid high 10 cycles, low 1 cycle, high again; request at cycle 20 → 16'h0001 (counter restarted); request at cycle 40 → 16'h0003.
- Opcode 16'h0042 in WAIT and in RUN → rsp_status=16'hFFFF both times; state, running and rtr_done unaffected.
- Host stalls rsp_ready=0 for 8 cycles on a ready response while rtr_valid drops → rsp_valid/rsp_status held at 16'h0003, cmd_ready=0 throughout; on accept rtr_done pulses once and running=1.
- In RUN, toggle rtr_valid and issue 3 status requests → each returns 16'h0003, rtr_done never pulses again.
- Assert reset while a response is pending in RESP → next cycle rsp_valid=0, cmd_ready=1, running=0, rtr_done=0; the next request returns 16'h0001.
